// File: rtl/reg_bank.sv
// 32x16 decode-stage register file: two combinational read ports with 4:1 forwarding muxes, imm override on B.
// Latency: reads are zero-cycle combinational, DM result retires on every clk edge; no backpressure.
module reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW_dm,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] fwd_b;

  // RW_dm == 0 doubles as "no write", which keeps R0 at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RW_dm != '0) begin
      regs[RW_dm] <= ans_dm;
    end
  end

  // No write-through: a same-cycle producer must be picked up via the forwarding selects.
  always_comb begin
    reg_a = regs[RA];
    reg_b = regs[RB];
  end

  always_comb begin
    A = reg_a;
    unique case (mux_sel_A)
      2'b00:   A = reg_a;
      2'b01:   A = ans_ex;
      2'b10:   A = ans_dm;
      default: A = ans_wb;
    endcase
  end

  always_comb begin
    fwd_b = reg_b;
    unique case (mux_sel_B)
      2'b00:   fwd_b = reg_b;
      2'b01:   fwd_b = ans_ex;
      2'b10:   fwd_b = ans_dm;
      default: fwd_b = ans_wb;
    endcase
  end

  assign B = imm_sel ? imm : fwd_b;

endmodule

// File: tb/tb_reg_bank.sv
// Randomized + directed bench for reg_bank against an array-based reference model.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ans_ex, ans_dm, ans_wb, imm;
  logic [4:0]  RA, RB, RW_dm;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic        imm_sel;
  logic [15:0] A, B;

  int total = 0;
  int bad   = 0;
  logic [15:0] model [32];
  logic [15:0] fwd_tab [4];
  bit cmp_en = 1'b0;

  reg_bank #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
    .imm(imm), .RA(RA), .RB(RB), .RW_dm(RW_dm), .mux_sel_A(mux_sel_A),
    .mux_sel_B(mux_sel_B), .imm_sel(imm_sel), .A(A), .B(B)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
  endtask

  function automatic logic [15:0] exp_a();
    logic [15:0] src [4];
    src[0] = model[RA]; src[1] = ans_ex; src[2] = ans_dm; src[3] = ans_wb;
    return src[mux_sel_A];
  endfunction

  function automatic logic [15:0] exp_b();
    logic [15:0] src [4];
    src[0] = model[RB]; src[1] = ans_ex; src[2] = ans_dm; src[3] = ans_wb;
    return imm_sel ? imm : src[mux_sel_B];
  endfunction

  // Model: the file takes ans_dm at each rising edge unless in reset or addressed to R0.
  always @(posedge clk) begin
    if (rst === 1'b0 && RW_dm != 5'd0) model[RW_dm] = ans_dm;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_A", A, exp_a());
      check("cycle_B", B, exp_b());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fwd_tab[0] = 16'h0000; fwd_tab[1] = 16'hC000; fwd_tab[2] = 16'hD000; fwd_tab[3] = 16'hE000;
    rst = 1'b1; clear_model();
    ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000; imm = 16'hFFFF;
    RA = 5'd5; RB = 5'd6; RW_dm = 5'd7;
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
    #1;
    cmp_en = 1'b1;
    check("rst_A", A, 16'h0000);
    check("rst_B", B, 16'h0000);

    // Release reset; a write to R0 must not stick.
    @(posedge clk); #1;
    rst = 1'b0; RW_dm = 5'd0; ans_dm = 16'hD000; RA = 5'd0;
    @(posedge clk); #1;
    check("r0_after_write", A, 16'h0000);

    // Write R7; before the edge the old value is visible, after it the new one.
    RW_dm = 5'd7; RB = 5'd7; #1;
    check("r7_pre_edge", B, 16'h0000);
    @(posedge clk); #1;
    RW_dm = 5'd0; #1;
    check("r7_post_edge", B, 16'hD000);

    // Forwarding on A with R5 = 0.
    RA = 5'd5;
    for (int s = 0; s < 4; s++) begin
      mux_sel_A = 2'(s); #1;
      check($sformatf("fwdA_%0d", s), A, fwd_tab[s]);
    end

    // Immediate priority on B, then forwarding; A ignores imm_sel.
    imm_sel = 1'b1; mux_sel_B = 2'b00; mux_sel_A = 2'b01; #1;
    check("imm_B", B, 16'hFFFF);
    check("imm_A_unaffected", A, 16'hC000);
    mux_sel_B = 2'b10; #1;
    check("imm_over_sel", B, 16'hFFFF);
    imm_sel = 1'b0;
    for (int s = 1; s < 4; s++) begin
      mux_sel_B = 2'(s); #1;
      check($sformatf("fwdB_%0d", s), B, fwd_tab[s]);
    end

    // Asynchronous reset between edges; writes blocked while held.
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; RB = 5'd7;
    @(posedge clk); #1;
    check("r7_loaded", B, 16'hD000);
    #2; rst = 1'b1; clear_model(); #1;
    check("async_rst_B", B, 16'h0000);
    RW_dm = 5'd7; ans_dm = 16'hD000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_blocks_write", B, 16'h0000);
    rst = 1'b0; RW_dm = 5'd0; #1;
    check("after_rst_B", B, 16'h0000);

    // Sweep: Ri = 1000+i.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      RW_dm = 5'(i); ans_dm = 16'h1000 + 16'(i);
    end
    @(posedge clk); #1;
    RW_dm = 5'd0; ans_dm = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i); #1;
      check($sformatf("sweep_A_%0d", i), A, (i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
      check($sformatf("sweep_B_%0d", 31 - i), B, (i == 31) ? 16'h0000 : 16'h1000 + 16'(31 - i));
    end

    // Randomized traffic with occasional resets, checked every cycle against the model.
    repeat (3000) begin
      @(posedge clk); #1;
      ans_ex    = 16'($urandom); ans_dm = 16'($urandom);
      ans_wb    = 16'($urandom); imm    = 16'($urandom);
      RA        = 5'($urandom);  RB     = 5'($urandom);
      RW_dm     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mux_sel_A = 2'($urandom);  mux_sel_B = 2'($urandom);
      imm_sel   = 1'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      if (rst) clear_model();
      #2;
      check("rand_mid_A", A, exp_a());
      check("rand_mid_B", B, exp_b());
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32-entry x 16-bit register file for the pipelined MIPS-style processor, read in the decode stage.
- Two combinational read ports (A, B) each pass through a 4:1 forwarding mux that selects register data or a bypassed result from the EX, DM or WB stage.
- Port B additionally has an immediate override for I-type operands.
- A single write port retires the DM-stage result into the file every clock.

Parameters:
- DATA_W, 16, width of registers, bypass buses and immediate.
- ADDR_W, 5, register address width; register count = 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- ans_ex  input  DATA_W  bypass value from EX stage output.
- ans_dm  input  DATA_W  DM-stage result; bypass value and register write data.
- ans_wb  input  DATA_W  bypass value from WB stage.
- imm  input  DATA_W  sign/zero-extended immediate (extension done upstream).
- RA  input  ADDR_W  read address, port A.
- RB  input  ADDR_W  read address, port B.
- RW_dm  input  ADDR_W  write address accompanying ans_dm.
- mux_sel_A  input  2  forwarding select, port A.
- mux_sel_B  input  2  forwarding select, port B.
- imm_sel  input  1  1 = B driven by imm; 0 = B driven by forwarding mux.
- A  output  DATA_W  operand A.
- B  output  DATA_W  operand B.

Behaviour:
- Storage: regs[0..31], each DATA_W bits.
- Reset:
  - rst high clears all 32 registers to 0 immediately, without waiting for a clock edge.
  - While rst is high, writes are blocked.
  - A and B stay combinational during reset, so register-sourced outputs read 0.
- Write:
  - On every rising clk with rst low, regs[RW_dm] <= ans_dm. There is no write enable.
  - RW_dm = 0 is the no-write destination; R0 is never modified.
- R0: hardwired; always reads 16'h0000.
- Reads:
  - Asynchronous and combinational: regA = regs[RA], regB = regs[RB].
  - Zero-cycle latency from any input change to A/B.
- Read during write to the same address: the read returns the pre-edge value until the edge. After the edge it returns the new value. No internal write-through; same-cycle bypass is the job of the forwarding selects.
- A mux, by mux_sel_A:
  - 00 -> regA
  - 01 -> ans_ex
  - 10 -> ans_dm
  - 11 -> ans_wb
- B mux, by mux_sel_B: same mapping using regB.
- Immediate override: B = imm when imm_sel = 1, otherwise the B mux output. imm_sel has priority over mux_sel_B.
- A is never affected by imm_sel.
- No arithmetic, no width conversion; all data paths are DATA_W wide, pass-through.
- Undefined or X selects are not required to be handled; all four codes of each 2-bit select are legal.

Test Plan:
- Reset/R0: assert rst, hold RA=5, RB=6, selects 00, imm_sel=0 -> A=0000, B=0000. Then release rst, set RW_dm=0, ans_dm=D000 and clock -> RA=0 still reads 0000.
- Write/read: rst low, RW_dm=7, ans_dm=D000, rising clk; then RB=7, mux_sel_B=00, imm_sel=0 -> B=D000. Check that before the edge B showed the old R7 value (0000).
- Forwarding A:
  - ans_ex=C000, ans_dm=D000, ans_wb=E000, RA=5 (holds 0).
  - mux_sel_A = 00/01/10/11 -> A = 0000/C000/D000/E000 respectively, combinationally.
- Forwarding B plus immediate: imm=FFFF, imm_sel=1 with mux_sel_B=00 -> B=FFFF. Then imm_sel=0, mux_sel_B=01 -> B=C000; mux_sel_B=10 -> D000; mux_sel_B=11 -> E000.
- Async reset mid-operation: load R7=D000, assert rst between clock edges -> RB=7/sel 00 reads 0000 immediately. Clock edges during reset with RW_dm=7 leave R7=0000.
- Write sweep: write 16'h1000+i to Ri for i=1..31, then read all via A and B -> each returns its value; R0 returns 0000.
